// File: rtl/opram_fetch.sv
// Read-side fetch unit for the op RAM: issues sequential reads, tracks them through the
// RAM latency with a tag pipeline, and buffers returned ops for the decoder.
module opram_fetch #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2,
  parameter int DEPTH  = RD_LAT + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              halt,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              wr_busy,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              op_valid,
  output logic [DATA_W-1:0] op,
  output logic [ADDR_W-1:0] op_addr,
  input  logic              op_ready,
  output logic              busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + RD_LAT + 1) + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Handshake: an op moves to the decoder on any cycle where op_valid && op_ready;
  // op/op_addr are held while op_valid && !op_ready, and op_valid only falls after a
  // transfer, on a jump, or on reset.

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [RD_LAT-1:0] tag_v;
  logic [ADDR_W-1:0] tag_a    [RD_LAT];
  logic [DATA_W-1:0] buf_op   [DEPTH];
  logic [ADDR_W-1:0] buf_addr [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     credit;
  logic              pop;
  logic              push;
  logic              do_jump;
  logic              issue;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CW'(tag_v[i]);
    end
  end

  assign op_valid = (count != '0);
  assign op       = op_valid ? buf_op[rd_ptr]   : '0;
  assign op_addr  = op_valid ? buf_addr[rd_ptr] : '0;
  assign pop      = op_valid & op_ready;

  // Reads in flight are counted as already occupying a buffer slot, so a
  // returning op always has room even if the decoder stalls.
  assign credit   = count + inflight - CW'(pop);
  assign do_jump  = (state == RUN) & jmp_valid & ~halt;
  assign issue    = (state == RUN) & ~halt & ~jmp_valid & ~wr_busy & (credit < CW'(DEPTH));
  assign push     = tag_v[RD_LAT-1] & ~do_jump;

  assign ram_rd_en = issue;
  assign ram_addr  = pc;
  assign busy      = (state == RUN) | (inflight != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= '0;
      tag_v  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (state == IDLE) begin
        if (start && !halt) begin
          state <= RUN;
          pc    <= start_addr;
        end
      end else begin
        if (halt) begin
          state <= IDLE;
        end else if (jmp_valid) begin
          pc <= jmp_addr;
        end else if (issue) begin
          pc <= pc + 1'b1;
        end
      end

      tag_v[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1] & ~do_jump;
      end

      if (do_jump) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= next_ptr(wr_ptr);
        if (pop)  rd_ptr <= next_ptr(rd_ptr);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Datapath storage carries no reset; validity is tracked by tag_v and count.
  always_ff @(posedge clk) begin
    tag_a[0] <= pc;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_a[i] <= tag_a[i-1];
    end
    if (push) begin
      buf_op[wr_ptr]   <= ram_dout;
      buf_addr[wr_ptr] <= tag_a[RD_LAT-1];
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count == CW'(DEPTH))));

endmodule

// File: tb/tb_opram_fetch.sv
// Directed bench for opram_fetch: a RAM model with two-cycle read latency feeds the DUT
// and a scoreboard queue checks every op handed to the decoder.
module tb_opram_fetch;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              halt;
  logic              jmp_valid;
  logic [ADDR_W-1:0] jmp_addr;
  logic              wr_busy;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;
  logic              op_valid;
  logic [DATA_W-1:0] op;
  logic [ADDR_W-1:0] op_addr;
  logic              op_ready;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  logic [DATA_W-1:0] ram [16];
  logic [DATA_W-1:0] ram_q1;

  opram_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .halt(halt),
    .jmp_valid(jmp_valid), .jmp_addr(jmp_addr), .wr_busy(wr_busy),
    .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .op_valid(op_valid), .op(op), .op_addr(op_addr), .op_ready(op_ready), .busy(busy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Pipeline-mode RAM: address register stage plus output register stage.
  always @(posedge clk) begin
    if (ram_rd_en) ram_q1 <= ram[ram_addr];
    ram_dout <= ram_q1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each transfer pops the next expected {addr, op}.
  always @(negedge clk) begin
    if (!rst && op_valid && op_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        assert (0) else begin
          n_err++;
          $error("FAIL extra_op: observed addr %0h op %0h expected none", op_addr, op);
        end
      end else begin
        chk("op_stream", {op_addr, op}, exp_q.pop_front());
      end
    end
  end

  function automatic logic [ADDR_W+DATA_W-1:0] ent(input int a);
    return {ADDR_W'(a), DATA_W'(8'h10 + (a % 16))};
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = DATA_W'(8'h10 + i);
    ram_q1 = '0; ram_dout = '0;
    rst = 1'b1; start = 1'b0; start_addr = '0; halt = 1'b0;
    jmp_valid = 1'b0; jmp_addr = '0; wr_busy = 1'b0; op_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_op_valid", op_valid, 0);
    chk("rst_op", op, 0);
    chk("rst_op_addr", op_addr, 0);
    chk("rst_rd_en", ram_rd_en, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Start from 0 and stream with op_ready high
    for (int a = 0; a < 9; a++) exp_q.push_back(ent(a));
    for (int c = 0; c <= 13; c++) begin
      @(posedge clk); #1;
      start = (c == 0); start_addr = '0; op_ready = 1'b1; halt = (c == 10);
      @(negedge clk);
      if (c == 0) chk("t1_idle_no_rd", ram_rd_en, 0);
      if (c == 1) chk("t1_first_rd", {ram_rd_en, ram_addr}, {1'b1, 4'd0});
      if (c == 3) chk("t1_not_yet", op_valid, 0);
      if (c == 4) chk("t1_first_op", {op_valid, op_addr, op}, {1'b1, 4'd0, 8'h10});
      if (c >= 5 && c <= 12) chk("t1_gapfree", op_valid, 1);
      if (c == 10) chk("t1_halt_no_rd", ram_rd_en, 0);
      if (c == 12) chk("t1_busy_low", busy, 0);
      if (c == 13) chk("t1_idle_addr", {op_valid, ram_addr}, {1'b0, 4'd9});
    end
    chk("t1_drained", exp_q.size(), 0);

    // Wrap and backpressure from 14
    exp_q.push_back(ent(14)); exp_q.push_back(ent(15));
    exp_q.push_back(ent(0));  exp_q.push_back(ent(1));
    for (int c = 0; c <= 12; c++) begin
      @(posedge clk); #1;
      start = (c == 0); start_addr = 4'd14; op_ready = (c >= 8); halt = (c == 8);
      @(negedge clk);
      if (c == 4) chk("t2_fourth_rd", {ram_rd_en, ram_addr}, {1'b1, 4'd1});
      if (c >= 5 && c <= 8) chk("t2_credit_stop", ram_rd_en, 0);
      if (c >= 4 && c <= 7) chk("t2_hold", {op_valid, op_addr, op}, {1'b1, 4'd14, 8'h1E});
      if (c == 8) chk("t2_busy_halt", busy, 1);
      if (c == 9) chk("t2_busy_low", busy, 0);
      if (c == 12) chk("t2_empty", op_valid, 0);
    end
    chk("t2_drained", exp_q.size(), 0);

    // Jump to 9 with reads outstanding
    for (int a = 0; a < 3; a++) exp_q.push_back(ent(a));
    exp_q.push_back(ent(9)); exp_q.push_back(ent(10));
    for (int c = 0; c <= 12; c++) begin
      @(posedge clk); #1;
      start = (c == 0); start_addr = '0; op_ready = 1'b1; halt = (c == 9);
      jmp_valid = (c == 6); jmp_addr = 4'd9;
      @(negedge clk);
      if (c == 6) chk("t3_jmp_no_rd", ram_rd_en, 0);
      if (c == 6) chk("t3_jmp_xfer", {op_valid, op_addr}, {1'b1, 4'd2});
      if (c == 7) chk("t3_new_rd", {ram_rd_en, ram_addr}, {1'b1, 4'd9});
      if (c >= 7 && c <= 9) chk("t3_flushed", op_valid, 0);
      if (c == 10) chk("t3_first_new", {op_valid, op_addr, op}, {1'b1, 4'd9, 8'h19});
      if (c == 12) chk("t3_empty", op_valid, 0);
    end
    jmp_valid = 1'b0;
    chk("t3_drained", exp_q.size(), 0);

    // Halt with two reads in flight and the decoder stalled
    exp_q.push_back(ent(0)); exp_q.push_back(ent(1));
    for (int c = 0; c <= 8; c++) begin
      @(posedge clk); #1;
      start = (c == 0); start_addr = '0; op_ready = (c >= 6); halt = (c == 3);
      @(negedge clk);
      if (c == 2) chk("t4_rd", {ram_rd_en, ram_addr}, {1'b1, 4'd1});
      if (c >= 3 && c <= 5) chk("t4_no_rd", ram_rd_en, 0);
      if (c == 4) chk("t4_busy_drain", busy, 1);
      if (c == 5) chk("t4_busy_low", busy, 0);
      if (c == 5) chk("t4_buffered", {op_valid, op}, {1'b1, 8'h10});
      if (c == 8) chk("t4_empty", op_valid, 0);
    end
    chk("t4_drained", exp_q.size(), 0);

    // Loader writes during streaming
    for (int a = 0; a < 6; a++) exp_q.push_back(ent(a));
    for (int c = 0; c <= 13; c++) begin
      @(posedge clk); #1;
      start = (c == 0); start_addr = '0; op_ready = 1'b1; halt = (c == 10);
      wr_busy = (c >= 5 && c <= 7);
      @(negedge clk);
      if (c >= 5 && c <= 7) chk("t5_stall", {ram_rd_en, ram_addr}, {1'b0, 4'd4});
      if (c == 7) chk("t5_before_gap", op_valid, 1);
      if (c >= 8 && c <= 10) chk("t5_gap", op_valid, 0);
      if (c == 11) chk("t5_resume", {op_valid, op_addr}, {1'b1, 4'd4});
      if (c == 13) chk("t5_empty", op_valid, 0);
    end
    wr_busy = 1'b0;
    chk("t5_drained", exp_q.size(), 0);

    // Reset mid-stream, then restart from 3
    exp_q.push_back(ent(3)); exp_q.push_back(ent(4));
    for (int c = 0; c <= 12; c++) begin
      @(posedge clk); #1;
      start = (c == 0 || c == 6); start_addr = (c < 6) ? 4'd0 : 4'd3;
      op_ready = (c >= 6); halt = (c == 9); rst = (c == 4);
      @(negedge clk);
      if (c == 4) chk("t6_pre_rst", op_valid, 1);
      if (c == 5) begin
        chk("t6_op_valid", op_valid, 0);
        chk("t6_op", op, 0);
        chk("t6_op_addr", op_addr, 0);
        chk("t6_rd_en", ram_rd_en, 0);
        chk("t6_ram_addr", ram_addr, 0);
        chk("t6_busy", busy, 0);
      end
      if (c == 7) chk("t6_restart_rd", {ram_rd_en, ram_addr}, {1'b1, 4'd3});
      if (c == 10) chk("t6_first_op", {op_valid, op_addr, op}, {1'b1, 4'd3, 8'h13});
      if (c == 12) chk("t6_empty", op_valid, 0);
    end
    chk("t6_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
